// File: rtl/serv_irq_sched.sv
// serv_irq_sched: masks and prioritises MEI/MSI/MTI, requests a trap, then streams mcause serially W bits per beat.
module serv_irq_sched #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_meip,
  input  logic         i_msip,
  input  logic         i_mtip,
  input  logic         i_mstatus_mie,
  input  logic [2:0]   i_mie,
  input  logic         i_trig_irq,
  input  logic         i_cnt_en,
  input  logic         i_cnt_done,
  output logic         o_irq_req,
  output logic         o_irq_taken,
  output logic [3:0]   o_cause_code,
  output logic [W-1:0] o_mcause,
  output logic         o_busy
);
  localparam int KW = (W == 4) ? 3 : 5;
  typedef enum logic {IDLE, TRAP} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_armed;
  logic [3:0]             r_cand;
  logic [KW-1:0]          r_k;
  logic [2:0]             w_raw, w_pend, w_take;
  logic                   w_elig, w_accept;
  logic [3:0]             w_code;
  logic [31:0]            w_word;
  assign w_raw    = {r_sync[SYNC_STAGES-1], i_msip, i_mtip};
  assign w_pend   = w_raw & i_mie & r_armed;
  assign w_elig   = |w_pend & i_mstatus_mie;
  assign w_code   = w_pend[2] ? 4'd11 : w_pend[1] ? 4'd3 : 4'd7;
  // the source to disarm is recovered from the registered candidate, so it matches the code actually taken
  assign w_take   = (r_cand == 4'd11) ? 3'b100 : (r_cand == 4'd3) ? 3'b010 : 3'b001;
  assign w_accept = (r_state == IDLE) && i_trig_irq && o_irq_req;
  assign w_word   = {1'b1, 27'b0, o_cause_code};
  assign o_mcause = o_busy ? w_word[32'(r_k) * W +: W] : '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_sync       <= '0;
      r_armed      <= 3'b111;
      r_cand       <= '0;
      r_k          <= '0;
      o_irq_req    <= 1'b0;
      o_irq_taken  <= 1'b0;
      o_cause_code <= '0;
      o_busy       <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_meip};
      o_irq_taken <= 1'b0;
      r_armed     <= (EDGE_MODE != 0) ? ((r_armed & ~(w_accept ? w_take : 3'b000)) | ~w_raw) : 3'b111;
      if (r_state == IDLE) begin
        o_irq_req <= w_elig;
        r_cand    <= w_code;
        if (w_accept) begin
          o_cause_code <= r_cand;
          o_irq_taken  <= 1'b1;
          o_irq_req    <= 1'b0;
          r_k          <= '0;
          o_busy       <= 1'b1;
          r_state      <= TRAP;
        end
      end else begin
        o_irq_req <= 1'b0;
        if (i_cnt_en) begin
          r_k <= r_k + KW'(1);
          if (i_cnt_done) begin
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_serv_irq_sched.sv
// tb_serv_irq_sched: directed scoreboard bench for a W=1 and a W=4 scheduler sharing the interrupt lines.
module tb_serv_irq_sched;
  logic       clk = 0, rst_n = 0;
  logic       meip = 0, msip = 0, mtip = 0, mst_mie = 0;
  logic [2:0] mie = 0;
  logic       trig = 0, cnt_en = 0, cnt_done = 0;
  logic       trig4 = 0, cnt_en4 = 0, cnt_done4 = 0;
  logic       req, taken, busy, req4, taken4, busy4;
  logic [3:0] code, code4, mcause4;
  logic [0:0] mcause;
  int         n_chk = 0, n_fail = 0;
  logic [3:0] q_code[$], q_code4[$];
  logic       q_beat[$];
  logic [3:0] q_beat4[$];

  always #5 clk = ~clk;

  serv_irq_sched #(.W(1), .SYNC_STAGES(2), .EDGE_MODE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_meip(meip), .i_msip(msip), .i_mtip(mtip),
    .i_mstatus_mie(mst_mie), .i_mie(mie), .i_trig_irq(trig), .i_cnt_en(cnt_en),
    .i_cnt_done(cnt_done), .o_irq_req(req), .o_irq_taken(taken), .o_cause_code(code),
    .o_mcause(mcause), .o_busy(busy));

  serv_irq_sched #(.W(4), .SYNC_STAGES(2), .EDGE_MODE(1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_meip(meip), .i_msip(msip), .i_mtip(mtip),
    .i_mstatus_mie(mst_mie), .i_mie(mie), .i_trig_irq(trig4), .i_cnt_en(cnt_en4),
    .i_cnt_done(cnt_done4), .o_irq_req(req4), .o_irq_taken(taken4), .o_cause_code(code4),
    .o_mcause(mcause4), .o_busy(busy4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: checks taken pulses and cause beats against the scoreboard queues
  always @(negedge clk) begin
    if (taken) begin
      if (q_code.size() == 0) chk("taken1_unexpected", 32'(taken), 32'd0);
      else chk("cause_code1", 32'(code), 32'(q_code.pop_front()));
    end
    if (taken4) begin
      if (q_code4.size() == 0) chk("taken4_unexpected", 32'(taken4), 32'd0);
      else chk("cause_code4", 32'(code4), 32'(q_code4.pop_front()));
    end
    if (busy && cnt_en) begin
      if (q_beat.size() == 0) chk("beat1_unexpected", 32'(busy), 32'd0);
      else chk("beat1", 32'(mcause), 32'(q_beat.pop_front()));
    end
    if (busy4 && cnt_en4) begin
      if (q_beat4.size() == 0) chk("beat4_unexpected", 32'(busy4), 32'd0);
      else chk("beat4", 32'(mcause4), 32'(q_beat4.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept1(input logic [3:0] c);
    trig = 1;
    q_code.push_back(c);
    step();
    trig = 0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_req_low", 32'(req), 32'd0);
  endtask

  task automatic stream1(input logic [3:0] c, input bit gap);
    logic [31:0] word;
    word = {1'b1, 27'b0, c};
    for (int i = 0; i < 32; i++) q_beat.push_back(word[i]);
    for (int i = 0; i < 32; i++) begin
      if (gap && i == 5) begin
        cnt_en = 0;
        cnt_done = 1;
        trig = 1;
        step();
        chk("hold_beat", 32'(mcause), 32'(word[5]));
        chk("hold_busy", 32'(busy), 32'd1);
        chk("trap_no_taken", 32'(taken), 32'd0);
        cnt_done = 0;
        trig = 0;
      end
      cnt_en = 1;
      cnt_done = (i == 31);
      step();
    end
    cnt_en = 0;
    cnt_done = 0;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_mcause", 32'(mcause), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_mcause", 32'(mcause), 32'd0);
    step();
    step();
    rst_n = 1;
    step();
    // single MTI, full 32-beat stream with a stalled beat
    mie = 3'b001;
    mst_mie = 1;
    mtip = 1;
    chk("req_before_edge", 32'(req), 32'd0);
    step();
    chk("mti_req", 32'(req), 32'd1);
    accept1(4'd7);
    stream1(4'd7, 1);
    // line held after being taken: stays disarmed until it drops
    repeat (3) begin
      step();
      chk("disarmed_req", 32'(req), 32'd0);
    end
    mtip = 0;
    step();
    chk("rearm_low_req", 32'(req), 32'd0);
    mtip = 1;
    step();
    chk("rearm_req", 32'(req), 32'd1);
    // global mask drops the request; later trigger is ignored
    mst_mie = 0;
    step();
    chk("mask_req", 32'(req), 32'd0);
    trig = 1;
    step();
    chk("mask_taken", 32'(taken), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    trig = 0;
    // accept in the same cycle the mask falls is still honoured
    mst_mie = 1;
    step();
    chk("unmask_req", 32'(req), 32'd1);
    mst_mie = 0;
    accept1(4'd7);
    stream1(4'd7, 0);
    mst_mie = 1;
    mtip = 0;
    step();
    // source drops in the accept cycle: trap still taken
    mtip = 1;
    step();
    chk("drop_req", 32'(req), 32'd1);
    mtip = 0;
    accept1(4'd7);
    stream1(4'd7, 0);
    // all three pending: 11, then 3, then 7, then nothing
    mie = 3'b111;
    meip = 1;
    msip = 1;
    mtip = 1;
    step();
    chk("prio_req", 32'(req), 32'd1);
    step();
    step();
    accept1(4'd11);
    stream1(4'd11, 0);
    step();
    accept1(4'd3);
    stream1(4'd3, 0);
    step();
    accept1(4'd7);
    stream1(4'd7, 0);
    repeat (2) begin
      step();
      chk("all_disarmed_req", 32'(req), 32'd0);
    end
    meip = 0;
    msip = 0;
    mtip = 0;
    repeat (4) step();
    // external line goes through the synchronizer
    mie = 3'b100;
    meip = 1;
    step();
    chk("meip_lat1", 32'(req), 32'd0);
    step();
    chk("meip_lat2", 32'(req), 32'd0);
    step();
    chk("meip_lat3", 32'(req), 32'd1);
    // W=4 instance streams code 11
    chk("w4_req", 32'(req4), 32'd1);
    trig4 = 1;
    q_code4.push_back(4'd11);
    step();
    trig4 = 0;
    chk("w4_busy", 32'(busy4), 32'd1);
    q_beat4.push_back(4'hB);
    repeat (6) q_beat4.push_back(4'h0);
    q_beat4.push_back(4'h8);
    for (int i = 0; i < 8; i++) begin
      cnt_en4 = 1;
      cnt_done4 = (i == 7);
      step();
      if (i == 6) chk("w4_busy_before_done", 32'(busy4), 32'd1);
    end
    cnt_en4 = 0;
    cnt_done4 = 0;
    chk("w4_end_busy", 32'(busy4), 32'd0);
    chk("w4_end_mcause", 32'(mcause4), 32'd0);
    // asynchronous reset in the middle of a trap
    accept1(4'd11);
    for (int i = 0; i < 4; i++) q_beat.push_back(i == 0 || i == 1 || i == 3);
    cnt_en = 1;
    repeat (4) step();
    cnt_en = 0;
    meip = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_taken", 32'(taken), 32'd0);
    chk("arst_mcause", 32'(mcause), 32'd0);
    chk("arst_code", 32'(code), 32'd0);
    step();
    rst_n = 1;
    step();
    chk("q_code_empty", 32'(q_code.size()), 32'd0);
    chk("q_beat_empty", 32'(q_beat.size()), 32'd0);
    chk("q_code4_empty", 32'(q_code4.size()), 32'd0);
    chk("q_beat4_empty", 32'(q_beat4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
